// File: rtl/link_sched_pkg.sv
// Shared definitions for the link-address write-back scheduler.
// Holds FSM encodings, slot indices, slot control ops and the PC increment.
// Pure definitions; no logic, no timing.
package link_sched_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SLOT_HOLD  = 2'd0,
    SLOT_LOAD  = 2'd1,
    SLOT_CLEAR = 2'd2
  } slot_op_e;

  localparam int SLOT_ID   = 0;
  localparam int SLOT_EX   = 1;
  localparam int SLOT_WB   = 2;
  localparam int NUM_SLOTS = 3;

  localparam int PC_INC = 4;

endpackage

// File: rtl/link_slot.sv
// One tracker slot: valid bit plus link address, with hold/load/clear control.
// Latency: the loaded value is visible one clock after the load.
// No backpressure of its own; hold is the only way to freeze it.
module link_slot
  import link_sched_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  slot_op_e        op,
  input  logic            din_v,
  input  logic [XLEN-1:0] din_addr,
  output logic            q_v,
  output logic [XLEN-1:0] q_addr
);

  // Slot register; an invalid entry always carries a zero address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_v    <= 1'b0;
      q_addr <= '0;
    end else begin
      case (op)
        SLOT_LOAD: begin
          q_v    <= din_v;
          q_addr <= din_v ? din_addr : '0;
        end
        SLOT_CLEAR: begin
          q_v    <= 1'b0;
          q_addr <= '0;
        end
        default: begin
          q_v    <= q_v;
          q_addr <= q_addr;
        end
      endcase
    end
  end

endmodule

// File: rtl/link_sched.sv
// Schedules jal/jalr link writes through ID/EX/WB slots with IF/ID arbitration.
// Latency: IF request writes on the 3rd edge, ID request on the 2nd, +1 per stall cycle.
// Stall freezes all slots and gates link_we; flush kills ID/EX-side slots and inserts bubbles.
module link_sched
  import link_sched_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_link,
  input  logic             id_link,
  input  logic [XLEN-1:0]  pc,
  input  logic             stall,
  input  logic             flush,
  output logic             link_we,
  output logic [XLEN-1:0]  link_addr,
  output logic             conflict,
  output logic [CNT_W-1:0] conflict_cnt,
  output logic [1:0]       state
);

  state_e                 state_q;
  state_e                 state_d;
  logic                   coll;
  logic                   conflict_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [XLEN-1:0]        pc_inc;

  slot_op_e               slot_op [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]   din_v;
  logic [XLEN-1:0]        din_a   [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]   slot_v;
  logic [XLEN-1:0]        slot_a  [NUM_SLOTS];

  // jal link value; wraps naturally at the top of the address space
  assign pc_inc = pc + XLEN'(PC_INC);

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    link_slot #(
      .XLEN(XLEN)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .op       (slot_op[g]),
      .din_v    (din_v[g]),
      .din_addr (din_a[g]),
      .q_v      (slot_v[g]),
      .q_addr   (slot_a[g])
    );
  end

  // Next state, slot control and IF/ID arbitration; flush beats stall beats requests
  always_comb begin
    state_d = state_q;
    coll    = 1'b0;
    din_v   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_op[i] = SLOT_HOLD;
      din_a[i]   = '0;
    end
    // WB only ever receives the EX entry
    din_v[SLOT_WB] = slot_v[SLOT_EX];
    din_a[SLOT_WB] = slot_a[SLOT_EX];

    if (flush) begin
      // EX instruction is already committed to the redirect, so it survives
      state_d          = ST_FLUSH;
      slot_op[SLOT_WB] = SLOT_LOAD;
      slot_op[SLOT_EX] = SLOT_CLEAR;
      slot_op[SLOT_ID] = SLOT_CLEAR;
    end else if (stall) begin
      state_d = (state_q == ST_FLUSH) ? ST_FLUSH : ST_STALL;
    end else begin
      state_d = ST_RUN;
      for (int i = 0; i < NUM_SLOTS; i++) slot_op[i] = SLOT_LOAD;
      if (state_q == ST_FLUSH) begin
        // wrong-path bubble: requests ignored, empty entry inserted
        din_v[SLOT_EX] = slot_v[SLOT_ID];
        din_a[SLOT_EX] = slot_a[SLOT_ID];
      end else begin
        coll = id_link & slot_v[SLOT_ID];
        if (id_link) begin
          din_v[SLOT_EX] = 1'b1;
          din_a[SLOT_EX] = pc;
        end else begin
          din_v[SLOT_EX] = slot_v[SLOT_ID];
          din_a[SLOT_EX] = slot_a[SLOT_ID];
        end
        if (if_link) begin
          din_v[SLOT_ID] = 1'b1;
          din_a[SLOT_ID] = pc_inc;
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Collision pulse and saturating collision counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      conflict_q <= coll;
      if (coll && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign link_we      = slot_v[SLOT_WB] & ~stall;
  assign link_addr    = slot_v[SLOT_WB] ? slot_a[SLOT_WB] : '0;
  assign conflict     = conflict_q;
  assign conflict_cnt = cnt_q;
  assign state        = state_q;

endmodule

// File: doc/link_sched.md
# link_sched

Pipeline-side scheduler for link-address (jal/jalr) write-back in the CPU core. Accepts link requests from IF (jal, address PC+4) and ID (jalr, address PC), carries each through a three-slot tracker aligned with the ID/EX/WB stages, and presents one link write per entry to the register file. Unlike a plain delay line, it honours pipeline stall and flush, arbitrates IF/ID collisions, and counts them.

## Interface
Parameters:
- XLEN, 32, address/data width
- CNT_W, 8, width of the conflict counter

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_link  in  1  IF-stage link request (jal fetched this cycle)
- id_link  in  1  ID-stage link request (jalr decoded this cycle)
- pc  in  XLEN  current PC, shared by both request sources
- stall  in  1  pipeline stall, freezes tracker
- flush  in  1  EX redirect, kills IF/ID-stage work
- link_we  out  1  one-cycle write-enable for the link register write
- link_addr  out  XLEN  link value; 0 when slot 2 is invalid
- conflict  out  1  registered pulse: ID request overwrote a valid IF entry
- conflict_cnt  out  CNT_W  saturating collision count
- state  out  2  FSM state (RUN=0, STALL=1, FLUSH=2)

## Operation
- Slots s0 (ID), s1 (EX), s2 (WB). Each slot holds valid bit plus XLEN address.
- Advance (state RUN, no stall, no flush), all at the same clock edge:
  - s2 <= s1
  - s1 <= id_link ? {1, pc} : s0
  - s0 <= if_link ? {1, pc+4} : {0, 0}
- pc+4 wraps modulo 2^XLEN. 0xFFFFFFFC gives 0.
- Collision: id_link while s0.valid. ID wins, the IF entry is dropped, conflict pulses next cycle, and conflict_cnt increments, saturating at 2^CNT_W-1.
- Output: link_addr = s2.valid ? s2.addr : 0.
- link_we = s2.valid & ~stall. Each entry is written exactly once.
- Stall: all slots hold, requests are ignored, and state goes to STALL.
- Flush (priority over stall and requests):
  - s2 <= s1, s1 <= 0, s0 <= 0. The EX instruction survives.
  - State goes to FLUSH.
- FSM transitions:
  - RUN → STALL on stall. RUN → FLUSH on flush.
  - STALL → RUN when stall drops. STALL → FLUSH on flush.
  - FLUSH: if_link and id_link are ignored (wrong-path bubble). Slots advance with empty inserts.
  - FLUSH → RUN next cycle if stall=0. If stall=1, stay in FLUSH with slots held.
  - A new flush in FLUSH restarts FLUSH.
- Reset (async, any time including mid-operation): all slots invalid/0, state RUN, conflict 0, conflict_cnt 0. link_we is deasserted immediately.

## Timing
- IF request: link_we is high 3 edges after the request edge. ID request: 2 edges. Both assume no stall.
- Each stall cycle adds one cycle of latency.
- All outputs are registered or derived from registers, except the ~stall gate on link_we.
- flush and stall are sampled at the same edge as the requests.

## Structure
- Shared package/def header holds:
  - state encodings ST_RUN, ST_STALL, ST_FLUSH
  - slot indices
  - the PC increment constant 4
- One natural sub-module: link_slot (valid+addr register with hold/load/clear). It is instantiated three times. FSM, arbitration and counter live in link_sched.

## Test plan
- Reset, pc=0x100, if_link one cycle → link_we high 3 cycles later, link_addr=0x104, single cycle.
- id_link at pc=0x200, no stall → link_we 2 cycles later, link_addr=0x200.
- if_link at 0x300, then id_link at 0x304 next cycle → conflict pulse, conflict_cnt=1, only 0x304 is written.
- Entry in s1, stall for 2 cycles → link_we stays 0 during stall, fires once after release, latency +2.
- Entries in s0 and s1, flush → only the s1 entry is written; state FLUSH for 1 cycle; if_link during FLUSH produces no write.
- 260 forced collisions with CNT_W=8 → conflict_cnt saturates at 255. rst_n low mid-stream → all outputs 0 asynchronously.
